// File: rtl/plane_normalizer.sv
// plane_normalizer: scales a plane by 1/|normal| using one shared multiplier and Newton-Raphson rsqrt.
// Define RANSAC_NORMALIZE_SATURATE_EN to saturate every multiply/accumulate instead of wrapping.
package plane_normalizer_pkg;
  typedef logic signed [47:0] fixed_t;
  typedef logic signed [95:0] product_t;
  typedef struct packed { fixed_t x; fixed_t y; fixed_t z; } vec3_t;
  typedef struct packed { vec3_t normal; fixed_t d; } plane_t;
endpackage

module plane_normalizer
  import plane_normalizer_pkg::*;
#(
  parameter int NEWTON_ITERS = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  plane_t in_plane,
  output logic   out_valid,
  input  logic   out_ready,
  output plane_t out_plane,
  output logic   out_degenerate
);

  // state | meaning
  // IDLE  | waiting for a plane
  // DOT   | s = x*x + y*y + z*z, one product per cycle
  // GUESS | y0 from leading-zero count of s, or bail out if s <= 0
  // ITER  | y*y, s*t, y*(3-t)/2 per iteration
  // SCALE | x, y, z, d multiplied by final y
  // DONE  | result held until consumer takes it
  typedef enum logic [2:0] {IDLE, DOT, GUESS, ITER, SCALE, DONE} state_t;

  localparam fixed_t ONE   = 48'sh000001000000;
  localparam fixed_t THREE = 48'sh000003000000;
`ifdef RANSAC_NORMALIZE_SATURATE_EN
  localparam fixed_t FIX_MAX = {1'b0, {47{1'b1}}};
  localparam fixed_t FIX_MIN = {1'b1, {47{1'b0}}};
`endif

  state_t r_state, w_state_nxt;
  plane_t r_in, r_out;
  fixed_t r_s, r_t, r_y;
  logic [1:0] r_step;
  logic [3:0] r_iter;
  logic r_deg;

  fixed_t w_a, w_b, w_mul, w_acc, w_3mt, w_y0;
  product_t w_prod;
  logic signed [48:0] w_sum, w_diff;
  logic w_s_le0, w_last_iter;
  logic [5:0] w_msb;
  logic signed [7:0] w_e, w_half;
  logic [7:0] w_sh;
  logic w_unused_bits;

  assign w_prod = product_t'(w_a) * product_t'(w_b);
  assign w_sum  = {r_s[47], r_s} + {w_mul[47], w_mul};
  assign w_diff = $signed({1'b0, THREE}) - $signed({r_t[47], r_t});
  assign w_unused_bits = ^{w_prod[95:72], w_prod[23:0], w_sum[48], w_diff[48]};

  // product >>> 24, then reduce to fixed_t
  always_comb begin
    w_mul = w_prod[71:24];
    w_acc = w_sum[47:0];
    w_3mt = w_diff[47:0];
`ifdef RANSAC_NORMALIZE_SATURATE_EN
    if (w_prod[95:71] != {25{w_prod[95]}}) w_mul = w_prod[95] ? FIX_MIN : FIX_MAX;
    if (w_sum[48] != w_sum[47])            w_acc = w_sum[48] ? FIX_MIN : FIX_MAX;
    if (w_diff[48] != w_diff[47])          w_3mt = w_diff[48] ? FIX_MIN : FIX_MAX;
`endif
  end

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 48; i++) begin
      if (r_s[i]) w_msb = 6'(i);
    end
    w_e    = $signed({2'b00, w_msb}) - 8'sd24;
    w_half = w_e >>> 1;
    w_sh   = w_half[7] ? 8'(-w_half) : 8'(w_half);
    w_y0   = w_half[7] ? (ONE << w_sh) : (ONE >> w_sh);
  end

  assign w_s_le0     = r_s[47] || (r_s == '0);
  assign w_last_iter = (r_step == 2'd2) && (r_iter == 4'(NEWTON_ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = DOT;
      end
      DOT:   if (r_step == 2'd2) w_state_nxt = GUESS;
      GUESS: w_state_nxt = w_s_le0 ? DONE : ITER;
      ITER:  if (w_last_iter) w_state_nxt = SCALE;
      SCALE: if (r_step == 2'd3) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_a = r_y;
    w_b = r_y;
    case (r_state)
      DOT: begin
        case (r_step)
          2'd0:    begin w_a = r_in.normal.x; w_b = r_in.normal.x; end
          2'd1:    begin w_a = r_in.normal.y; w_b = r_in.normal.y; end
          default: begin w_a = r_in.normal.z; w_b = r_in.normal.z; end
        endcase
      end
      ITER: begin
        if (r_step == 2'd1) begin
          w_a = r_s;
          w_b = r_t;
        end else if (r_step == 2'd2) begin
          w_b = w_3mt;
        end
      end
      SCALE: begin
        case (r_step)
          2'd0:    w_a = r_in.normal.x;
          2'd1:    w_a = r_in.normal.y;
          2'd2:    w_a = r_in.normal.z;
          default: w_a = r_in.d;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in   <= '0;
      r_out  <= '0;
      r_s    <= '0;
      r_t    <= '0;
      r_y    <= '0;
      r_step <= '0;
      r_iter <= '0;
      r_deg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_in   <= in_plane;
          r_s    <= '0;
          r_step <= '0;
          r_iter <= '0;
          r_deg  <= 1'b0;
        end
        DOT: begin
          r_s    <= w_acc;
          r_step <= (r_step == 2'd2) ? 2'd0 : r_step + 2'd1;
        end
        GUESS: begin
          if (w_s_le0) begin
            r_out <= r_in;
            r_deg <= 1'b1;
          end else begin
            r_y <= w_y0;
          end
        end
        ITER: begin
          case (r_step)
            2'd0:    begin r_t <= w_mul; r_step <= 2'd1; end
            2'd1:    begin r_t <= w_mul; r_step <= 2'd2; end
            default: begin
              r_y    <= w_mul >>> 1;
              r_step <= 2'd0;
              r_iter <= r_iter + 4'd1;
            end
          endcase
        end
        SCALE: begin
          case (r_step)
            2'd0:    r_out.normal.x <= w_mul;
            2'd1:    r_out.normal.y <= w_mul;
            2'd2:    r_out.normal.z <= w_mul;
            default: r_out.d        <= w_mul;
          endcase
          r_step <= r_step + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_plane      = r_out;
  assign out_degenerate = r_deg;

endmodule

// File: doc/plane_normalizer.md
PLANE_NORMALIZER -- requirements
Module: plane_normalizer

Interface
REQ-001 SHALL have parameter NEWTON_ITERS, default 3, giving the number of Newton-Raphson rsqrt iterations (legal range 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1: in_plane is valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts a plane this cycle.
REQ-006 SHALL have port in_plane, input, plane_t (192 bits: normal.x, normal.y, normal.z, d; each fixed_t, 48-bit signed, 24 fraction bits).
REQ-007 SHALL have port out_valid, output, 1: out_plane and out_degenerate are valid.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port out_plane, output, plane_t: input plane with normal and d scaled by 1/|normal|.
REQ-010 SHALL have port out_degenerate, output, 1: |normal|^2 <= 0, so out_plane equals in_plane unscaled.

Function
REQ-011 SHALL accept a plane on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 only in state IDLE.
REQ-012 SHALL use one shared multiplier: 96-bit product_t, result = product >>> 24, then reduced to fixed_t per REQ-024.
REQ-013 SHALL sequence IDLE -> DOT (3 cycles) -> GUESS (1) -> ITER (3 cycles per iteration x NEWTON_ITERS) -> SCALE (4) -> DONE.
REQ-014 DOT SHALL accumulate s = x*x + y*y + z*z, one product per cycle, and add with the same reduction as the multiply.
REQ-015 After DOT, if s <= 0 the block SHALL go straight to DONE with out_plane = captured input and out_degenerate = 1.
REQ-016 GUESS SHALL compute e = 23 - lzc(s), which is floor(log2 s) in real units, and set y0 = one() shifted by -(e >>> 1): left if positive, right if negative.
REQ-017 Each ITER iteration SHALL compute, one multiply per cycle: t = y*y; t = s*t; y = (y * (3.0 - t)) >>> 1.
REQ-018 SCALE SHALL multiply normal.x, normal.y, normal.z and d by the final y, one per cycle, in that order.
REQ-019 out_valid SHALL rise exactly 8 + 3*NEWTON_ITERS cycles after the accepting edge: 17 for the default. A degenerate plane SHALL take 4 cycles.
REQ-020 In DONE, out_valid = 1 and out_plane/out_degenerate SHALL hold stable until out_valid and out_ready are both 1.
REQ-021 On that output handshake the state SHALL return to IDLE. in_ready = 1 the next cycle, and no input is accepted in the same cycle.
REQ-022 The captured input SHALL be registered at acceptance; later changes on in_plane SHALL have no effect.

Reset
REQ-023 While rst = 1, at any state including mid-ITER: state = IDLE, out_valid = 0, in_ready = 1 on the cycle after reset, out_plane = 0, out_degenerate = 0. Any in-flight plane SHALL be discarded.

Configuration
REQ-024 With macro RANSAC_NORMALIZE_SATURATE_EN defined, every multiply and accumulate result SHALL saturate to [-2^47, 2^47-1]. Without it, the upper bits SHALL be truncated (two's-complement wrap).

Verification
REQ-025 in (0,0,2), d=4 -> out (0,0,1), d=2, each within 2^-16; out_valid exactly 17 cycles after accept; out_degenerate=0.
REQ-026 in (3,4,0), d=10 -> out (0.6,0.8,0), d=2, each within 2^-16.
REQ-027 in (0,0,0), d=5 -> out_valid after 4 cycles; out_degenerate=1; out_plane = (0,0,0), d=5.
REQ-028 Hold out_ready=0 for 5 cycles in DONE -> out_plane stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle, and a back-to-back second plane is accepted.
REQ-029 Assert rst for 1 cycle during ITER -> out_valid=0 and in_ready=1 the next cycle; no result is ever emitted for that plane.
REQ-030 in (2^22,0,0), d=0 -> with the macro: out_degenerate=0 and out x > 0. Without the macro: s wraps to 0, so out_degenerate=1.
